// File: rtl/spin_readout.sv
// Anneal sequencer and phase readout for the coupled-oscillator array: enables the array, lets it
// settle, counts per-oscillator phase mismatches against oscillator 0 and decodes one spin each.
module spin_readout #(
  parameter int N             = 3,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_cycles,
  input  logic [N-1:0]     osc_in,
  output logic             osc_rstn,
  output logic             busy,
  output logic [N-1:0]     spins,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DECIDE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [CNT_W-1:0]                   win_q, win_d;
  logic [N-1:0][CNT_W-1:0]            mis_q, mis_d;
  logic [SYNC_STAGES-1:0][N-1:0]      sync_q, sync_d;
  logic [N-1:0]                       spins_q, spins_d;
  logic                               osc_rstn_q, osc_rstn_d;
  logic                               busy_q, busy_d;
  logic                               out_valid_q, out_valid_d;
  logic [N-1:0]                       osc_s;

  assign osc_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    mis_d   = mis_q;
    spins_d = spins_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], osc_in};

    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = sample_cycles;
          cnt_d   = '0;
          mis_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          // An empty sampling window skips straight to the decision with all counts at zero.
          state_d = (win_q == '0) ? DECIDE : SAMPLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      SAMPLE: begin
        for (int i = 1; i < N; i++) begin
          mis_d[i] = mis_q[i] + CNT_W'(osc_s[i] ^ osc_s[0]);
        end
        if (cnt_q == win_q - ONE) begin
          cnt_d   = '0;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DECIDE: begin
        // {mis, 0} is 2*mis at CNT_W+1 bits; a tie with the window decodes to 0.
        spins_d = '0;
        for (int i = 1; i < N; i++) begin
          spins_d[i] = {mis_q[i], 1'b0} > {1'b0, win_q};
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    osc_rstn_d  = (state_d == SETTLE) || (state_d == SAMPLE) || (state_d == DECIDE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      mis_q       <= '0;
      sync_q      <= '0;
      spins_q     <= '0;
      osc_rstn_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      mis_q       <= mis_d;
      sync_q      <= sync_d;
      spins_q     <= spins_d;
      osc_rstn_q  <= osc_rstn_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign osc_rstn  = osc_rstn_q;
  assign busy      = busy_q;
  assign spins     = spins_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_spin_readout.sv
// Randomized bench for spin_readout: cycle-accurate handshake/enable timing plus a
// majority-vote reference model computed from the recorded oscillator waveforms.
module tb_spin_readout;

  localparam int NN = 3;
  localparam int CW = 16;
  localparam int S  = 4;
  localparam int SY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] sample_cycles = '0;
  logic [NN-1:0] osc_in = '0;
  logic          osc_rstn;
  logic          busy;
  logic [NN-1:0] spins;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [NN-1:0] hist [0:32767];
  logic [NN-1:0] prev_spins = '0;

  int gen_mode = 0;
  int shift_amt [NN];
  logic [NN-1:0] inv_mask = '0;
  int cnt_lo = 0;
  int cnt_n = 0;

  spin_readout #(
    .N(NN), .CNT_W(CW), .SETTLE_CYCLES(S), .SYNC_STAGES(SY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_cycles(sample_cycles),
    .osc_in(osc_in), .osc_rstn(osc_rstn), .busy(busy), .spins(spins),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator waveform generator; every value driven is recorded for the reference model.
  always @(negedge clk) begin
    logic [NN-1:0] v;
    v = '0;
    case (gen_mode)
      1: for (int i = 0; i < NN; i++) v[i] = (((cyc + shift_amt[i]) % 7) < 4) ^ inv_mask[i];
      2: v[1] = (cyc >= cnt_lo) && (cyc < cnt_lo + cnt_n);
      default: v = NN'($urandom);
    endcase
    osc_in = v;
    hist[cyc] = v;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Spin i is 1 when it disagreed with oscillator 0 in strictly more than half the window.
  // The window covers the win cycles after settling; each sample sees osc_in SY cycles late.
  function automatic logic [NN-1:0] modelSpins(input int t0, input int win);
    logic [NN-1:0] r;
    r = '0;
    for (int i = 1; i < NN; i++) begin
      int m;
      m = 0;
      for (int k = 0; k < win; k++) begin
        logic [NN-1:0] x;
        x = hist[t0 + S + 1 + k - SY];
        m += int'(x[i] ^ x[0]);
      end
      r[i] = (2 * m) > win;
    end
    return r;
  endfunction

  // Runs one anneal from the current (idle) cycle and completes the handshake after hold_wait cycles.
  task automatic applyStimulus(input int win, input int hold_wait);
    int t0, rel, last;
    logic [NN-1:0] exp_new;
    t0 = cyc;
    last = S + win + 2 + hold_wait;
    exp_new = prev_spins;
    start = 1'b1;
    sample_cycles = CW'(win);
    out_ready = 1'($urandom_range(0, 1));
    do begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == S + win + 2) exp_new = modelSpins(t0, win);
      checkOutput("osc_rstn", 32'(osc_rstn), 32'(rel >= 1 && rel <= S + win + 1));
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("out_valid", 32'(out_valid), 32'(rel >= S + win + 2));
      checkOutput("spins", 32'(spins), 32'((rel >= S + win + 2) ? exp_new : prev_spins));
      sample_cycles = CW'($urandom);
      if (rel < S + win + 2) begin
        start = ($urandom_range(0, 7) == 0);
        out_ready = 1'($urandom_range(0, 1));
      end else if (rel < last) begin
        start = ($urandom_range(0, 3) == 0);
        out_ready = 1'b0;
      end else begin
        start = 1'b0;
        out_ready = 1'b1;
      end
    end while (rel < last);
    @(negedge clk);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_osc_rstn", 32'(osc_rstn), 32'd0);
    checkOutput("idle_spins", 32'(spins), 32'(exp_new));
    prev_spins = exp_new;
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic resetMidSample();
    int t0;
    t0 = cyc;
    start = 1'b1;
    sample_cycles = CW'(100);
    repeat (S + 51) begin
      @(negedge clk);
      start = 1'b0;
      sample_cycles = CW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_osc_rstn", 32'(osc_rstn), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_spins", 32'(spins), 32'd0);
    out_ready = 1'b1;
    repeat (150) begin
      @(negedge clk);
      checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
    out_ready = 1'b0;
    prev_spins = '0;
  endtask

  initial begin
    for (int i = 0; i < NN; i++) shift_amt[i] = 0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_osc_rstn", 32'(osc_rstn), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_spins", 32'(spins), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    gen_mode = 1;
    inv_mask = 3'b000;
    applyStimulus(100, 0);
    inv_mask = 3'b010;
    applyStimulus(100, 0);
    inv_mask = 3'b110;
    applyStimulus(100, 0);
    inv_mask = 3'b000;
    shift_amt[1] = 2;
    applyStimulus(100, 0);
    shift_amt[1] = 0;

    gen_mode = 2;
    cnt_n = 50;
    cnt_lo = cyc + S + 1 - SY;
    applyStimulus(100, 0);
    cnt_n = 51;
    cnt_lo = cyc + S + 1 - SY;
    applyStimulus(100, 0);

    gen_mode = 0;
    applyStimulus(0, 0);

    gen_mode = 1;
    inv_mask = 3'b010;
    applyStimulus(100, 20);

    gen_mode = 0;
    resetMidSample();
    gen_mode = 1;
    inv_mask = 3'b100;
    applyStimulus(100, 0);

    for (int r = 0; r < 10; r++) begin
      gen_mode = (r % 2 == 0) ? 0 : 1;
      inv_mask = NN'($urandom);
      for (int i = 0; i < NN; i++) shift_amt[i] = $urandom_range(0, 6);
      applyStimulus($urandom_range(0, 150), $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
